// File: rtl/floo_edge_err_responder.sv
// Mesh-edge terminator: swallows misrouted narrow AXI requests and answers each with DECERR.
// Optional error counter / first-source capture is built only when FLOO_EDGE_ERR_CNT_EN is defined.
//
// state   | meaning
// IDLE    | waiting for a request; AW/AR are captured, stray W and reserved are dropped
// W_DRAIN | discarding W beats of a captured AW until the last beat
// B_SEND  | presenting one B DECERR response
// R_SEND  | presenting R DECERR beats, counter holds beats remaining after this one

module floo_edge_err_responder #(
    parameter int unsigned IdW    = 6,
    parameter int unsigned TxnIdW = 4,
    parameter int unsigned DataW  = 64,
    parameter int unsigned CntW   = 16
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              req_valid_i,
    output logic              req_ready_o,
    input  logic [1:0]        req_ch_i,
    input  logic [IdW-1:0]    req_src_id_i,
    input  logic [TxnIdW-1:0] req_txn_id_i,
    input  logic [7:0]        req_len_i,
    input  logic              req_last_i,
    output logic              rsp_valid_o,
    input  logic              rsp_ready_i,
    output logic              rsp_ch_o,
    output logic [IdW-1:0]    rsp_dst_id_o,
    output logic [TxnIdW-1:0] rsp_txn_id_o,
    output logic [1:0]        rsp_resp_o,
    output logic              rsp_last_o,
    output logic [DataW-1:0]  rsp_data_o,
    output logic [CntW-1:0]   err_cnt_o,
    output logic [IdW-1:0]    err_src_o
);

    localparam logic [1:0] CH_AW = 2'd0;
    localparam logic [1:0] CH_W  = 2'd1;
    localparam logic [1:0] CH_AR = 2'd2;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        W_DRAIN = 2'd1,
        B_SEND  = 2'd2,
        R_SEND  = 2'd3
    } state_e;

    state_e              state_q, state_d;
    logic [IdW-1:0]      src_q, src_d;
    logic [TxnIdW-1:0]   txn_q, txn_d;
    logic [7:0]          cnt_q, cnt_d;
    logic                req_hs, rsp_hs;

    // All response outputs decode flops only, so there is no path from req_* to rsp_*.
    assign req_ready_o  = (state_q == IDLE) || (state_q == W_DRAIN);
    assign rsp_valid_o  = (state_q == B_SEND) || (state_q == R_SEND);
    assign rsp_ch_o     = (state_q == R_SEND);
    assign rsp_last_o   = (state_q == B_SEND) || ((state_q == R_SEND) && (cnt_q == 8'd0));
    assign rsp_resp_o   = rsp_valid_o ? 2'b11 : 2'b00;
    assign rsp_dst_id_o = src_q;
    assign rsp_txn_id_o = txn_q;
    assign rsp_data_o   = '0;

    assign req_hs = req_valid_i && req_ready_o;
    assign rsp_hs = rsp_valid_o && rsp_ready_i;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            src_q   <= '0;
            txn_q   <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            src_q   <= src_d;
            txn_q   <= txn_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        src_d   = src_q;
        txn_d   = txn_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                if (req_hs) begin
                    if (req_ch_i == CH_AW) begin
                        src_d   = req_src_id_i;
                        txn_d   = req_txn_id_i;
                        state_d = W_DRAIN;
                    end else if (req_ch_i == CH_AR) begin
                        src_d   = req_src_id_i;
                        txn_d   = req_txn_id_i;
                        cnt_d   = req_len_i;
                        state_d = R_SEND;
                    end
                end
            end
            W_DRAIN: begin
                // Extra AW/AR here are accepted but never overwrite the capture.
                if (req_hs && (req_ch_i == CH_W) && req_last_i) begin
                    state_d = B_SEND;
                end
            end
            B_SEND: begin
                if (rsp_hs) begin
                    state_d = IDLE;
                end
            end
            R_SEND: begin
                if (rsp_hs) begin
                    if (cnt_q == 8'd0) begin
                        state_d = IDLE;
                    end else begin
                        cnt_d = cnt_q - 8'd1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

`ifdef FLOO_EDGE_ERR_CNT_EN
    logic [CntW-1:0] err_cnt_q;
    logic [IdW-1:0]  err_src_q;

    // A zero count can only mean no error has completed yet, since the counter saturates.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            err_cnt_q <= '0;
            err_src_q <= '0;
        end else if (rsp_hs && rsp_last_o) begin
            if (err_cnt_q == '0) begin
                err_src_q <= src_q;
            end
            if (err_cnt_q != '1) begin
                err_cnt_q <= err_cnt_q + CntW'(1);
            end
        end
    end

    assign err_cnt_o = err_cnt_q;
    assign err_src_o = err_src_q;
`else
    assign err_cnt_o = '0;
    assign err_src_o = '0;
`endif

endmodule
